add_cmd_sequencer: RTL

//  Hardware initiator for the driver command interface (opcode/id/in/addr -> out).
//  On start: latches LANES operand pairs, pings the driver, writes A and B operand

---
 rtl/add_cmd_sequencer.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/add_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : add_cmd_sequencer
// Brief   : Drives the add-lane driver through ping, A/B writes, settle and Y
//           reads, then checks every Y lane against the latched A+B.
// Revision: 1.0
// ============================================================================
module add_cmd_sequencer #(
    parameter int LANES  = 4,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [32*LANES-1:0]   i_a_vec,
    input  logic [32*LANES-1:0]   i_b_vec,
    output logic [31:0]           o_opcode,
    output logic [31:0]           o_id,
    output logic [31:0]           o_in,
    output logic [31:0]           o_addr,
    input  logic [31:0]           i_out_rd,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [32*LANES-1:0]   o_result_vec,
    output logic [LANES-1:0]      o_mismatch,
    output logic                  o_alive_err
);

    localparam int LW = (LANES  > 1) ? $clog2(LANES)  : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [LW-1:0] C_LAST_LANE   = LW'(LANES - 1);
    localparam logic [SW-1:0] C_LAST_SETTLE = SW'(SETTLE - 1);

    localparam logic [31:0] C_ALIVE    = 32'hDEADBEEF;
    localparam logic [31:0] C_OP_PING  = 32'd0;
    localparam logic [31:0] C_OP_WRITE = 32'd1;
    localparam logic [31:0] C_OP_READ  = 32'd2;
    localparam logic [31:0] C_OP_NOP   = 32'd3;
    localparam logic [31:0] C_ID_NONE  = 32'd0;
    localparam logic [31:0] C_ID_A     = 32'd1;
    localparam logic [31:0] C_ID_B     = 32'd2;
    localparam logic [31:0] C_ID_Y     = 32'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PING   = 3'd1,
        S_WR_A   = 3'd2,
        S_WR_B   = 3'd3,
        S_SETTLE = 3'd4,
        S_RD_Y   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LW-1:0]       r_k;
    logic [LW-1:0]       w_k_nxt;
    logic [SW-1:0]       r_scnt;
    logic [SW-1:0]       w_scnt_nxt;
    logic [32*LANES-1:0] r_a;
    logic [32*LANES-1:0] r_b;

    logic                w_accept;
    logic [31:0]         w_opcode_nxt;
    logic [31:0]         w_id_nxt;
    logic [31:0]         w_in_nxt;
    logic [31:0]         w_addr_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic [31:0]         w_exp_sum;

    assign w_accept  = (r_state == S_IDLE) && i_start;
    // Carry-out is intentionally dropped: the adder lanes are 32-bit wrap-around.
    assign w_exp_sum = r_a[32*r_k +: 32] + r_b[32*r_k +: 32];

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_scnt_nxt  = r_scnt;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_PING;
                end
                w_k_nxt = '0;
            end
            S_PING: begin
                w_state_nxt = S_WR_A;
                w_k_nxt     = '0;
            end
            S_WR_A: begin
                if (r_k == C_LAST_LANE) begin
                    w_state_nxt = S_WR_B;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            S_WR_B: begin
                if (r_k == C_LAST_LANE) begin
                    w_state_nxt = S_SETTLE;
                    w_k_nxt     = '0;
                    w_scnt_nxt  = '0;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_scnt == C_LAST_SETTLE) begin
                    w_state_nxt = S_RD_Y;
                    w_scnt_nxt  = '0;
                end else begin
                    w_scnt_nxt = r_scnt + 1'b1;
                end
            end
            S_RD_Y: begin
                if (r_k == C_LAST_LANE) begin
                    w_state_nxt = S_DONE;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = '0;
                w_scnt_nxt  = '0;
            end
        endcase
    end

    // Command outputs are decoded from the next state so they are registered
    // and line up exactly with the state they belong to.
    always_comb begin
        w_opcode_nxt = C_OP_NOP;
        w_id_nxt     = C_ID_NONE;
        w_in_nxt     = '0;
        w_addr_nxt   = '0;
        w_busy_nxt   = 1'b1;
        w_done_nxt   = 1'b0;
        case (w_state_nxt)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
            end
            S_PING: begin
                w_opcode_nxt = C_OP_PING;
            end
            S_WR_A: begin
                w_opcode_nxt = C_OP_WRITE;
                w_id_nxt     = C_ID_A;
                w_addr_nxt   = {{(32-LW){1'b0}}, w_k_nxt};
                w_in_nxt     = r_a[32*w_k_nxt +: 32];
            end
            S_WR_B: begin
                w_opcode_nxt = C_OP_WRITE;
                w_id_nxt     = C_ID_B;
                w_addr_nxt   = {{(32-LW){1'b0}}, w_k_nxt};
                w_in_nxt     = r_b[32*w_k_nxt +: 32];
            end
            S_SETTLE: begin
                w_opcode_nxt = C_OP_NOP;
            end
            S_RD_Y: begin
                w_opcode_nxt = C_OP_READ;
                w_id_nxt     = C_ID_Y;
                w_addr_nxt   = {{(32-LW){1'b0}}, w_k_nxt};
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_scnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_scnt  <= w_scnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_opcode <= C_OP_NOP;
            o_id     <= C_ID_NONE;
            o_in     <= '0;
            o_addr   <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_opcode <= w_opcode_nxt;
            o_id     <= w_id_nxt;
            o_in     <= w_in_nxt;
            o_addr   <= w_addr_nxt;
            o_busy   <= w_busy_nxt;
            o_done   <= w_done_nxt;
        end
    end

    // Operand latch and response capture; result_vec is only overwritten lane by lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            o_result_vec <= '0;
            o_mismatch   <= '0;
            o_alive_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a         <= i_a_vec;
                r_b         <= i_b_vec;
                o_mismatch  <= '0;
                o_alive_err <= 1'b0;
            end
            if (r_state == S_PING) begin
                o_alive_err <= (i_out_rd != C_ALIVE);
            end
            if (r_state == S_RD_Y) begin
                o_result_vec[32*r_k +: 32] <= i_out_rd;
                o_mismatch[r_k]            <= (i_out_rd != w_exp_sum);
            end
        end
    end

endmodule
`default_nettype wire
